// File: rtl/spi_register_bank.sv
// Command decoder and register file behind the SPI slave byte receiver.
// The first byte of a transaction selects read/write and a start address; later bytes auto-increment.
module spi_register_bank #(
    parameter int unsigned REG_COUNT   = 16,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Active_i,
    input  logic [7:0]             ByteData_i,
    input  logic                   ByteDone_i,
    output logic [7:0]             TxByte_o,
    output logic [8*REG_COUNT-1:0] Regs_o,
    output logic                   WriteStrobe_o,
    output logic [ADDR_WIDTH-1:0]  WriteAddr_o,
    output logic                   AddrError_o
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCmd     = 3'd1;
    localparam logic [2:0] StWrite   = 3'd2;
    localparam logic [2:0] StRead    = 3'd3;
    localparam logic [2:0] StDiscard = 3'd4;

    localparam logic [7:0] RegCountByte = 8'(REG_COUNT);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_inc, cmd_addr;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            tx_q, tx_d;
    logic                  strobe_q, strobe_d;
    logic                  err_q, err_d;
    logic                  active_q;
    logic                  addr_bad;
    logic [7:0]            regs_q [REG_COUNT];

    always_comb begin
        ptr_inc  = ptr_q + ADDR_WIDTH'(1);
        cmd_addr = ByteData_i[ADDR_WIDTH-1:0];
        addr_bad = {1'b0, ByteData_i[6:0]} >= RegCountByte;

        state_d  = state_q;
        ptr_d    = ptr_q;
        tx_d     = tx_q;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        err_d    = err_q;

        // Abort beats the start edge, which beats any coincident byte.
        if (!Active_i) begin
            state_d = StIdle;
        end else if (!active_q) begin
            state_d = StCmd;
            err_d   = 1'b0;
            tx_d    = 8'h00;
        end else if (ByteDone_i) begin
            case (state_q)
                StCmd: begin
                    if (addr_bad) begin
                        err_d   = 1'b1;
                        tx_d    = 8'h00;
                        state_d = StDiscard;
                    end else begin
                        ptr_d = cmd_addr;
                        if (ByteData_i[7]) begin
                            state_d = StRead;
                            tx_d    = regs_q[cmd_addr];
                        end else begin
                            state_d = StWrite;
                        end
                    end
                end
                StWrite: begin
                    strobe_d = 1'b1;
                    waddr_d  = ptr_q;
                    ptr_d    = ptr_inc;
                end
                StRead: begin
                    ptr_d = ptr_inc;
                    tx_d  = regs_q[ptr_inc];
                end
                StDiscard: begin
                    tx_d = 8'h00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            waddr_q  <= '0;
            tx_q     <= 8'h00;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            waddr_q  <= waddr_d;
            tx_q     <= tx_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            active_q <= Active_i;
            if (strobe_d) begin
                regs_q[ptr_q] <= ByteData_i;
            end
        end
    end

    for (genvar i = 0; i < int'(REG_COUNT); i++) begin : g_regs_out
        assign Regs_o[8*i +: 8] = regs_q[i];
    end

    assign TxByte_o      = tx_q;
    assign WriteStrobe_o = strobe_q;
    assign WriteAddr_o   = waddr_q;
    assign AddrError_o   = err_q;

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed plus randomized transactions against a simple array model of the register bank.
module tb_spi_register_bank;

    localparam int RC = 16;
    localparam int AW = 4;
    localparam int VW = 8 * RC;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Active_i;
    logic [7:0]    ByteData_i;
    logic          ByteDone_i;
    logic [7:0]    TxByte_o;
    logic [VW-1:0] Regs_o;
    logic          WriteStrobe_o;
    logic [AW-1:0] WriteAddr_o;
    logic          AddrError_o;

    spi_register_bank #(
        .REG_COUNT  (RC),
        .ADDR_WIDTH (AW),
        .RESET_VALUE(8'h00)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Active_i     (Active_i),
        .ByteData_i   (ByteData_i),
        .ByteDone_i   (ByteDone_i),
        .TxByte_o     (TxByte_o),
        .Regs_o       (Regs_o),
        .WriteStrobe_o(WriteStrobe_o),
        .WriteAddr_o  (WriteAddr_o),
        .AddrError_o  (AddrError_o)
    );

    always #5 Clock = ~Clock;

    logic [7:0] mregs [RC];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        logic [VW-1:0] e;
        for (int i = 0; i < RC; i++) e[8*i +: 8] = mregs[i];
        check(tag, Regs_o, e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        ByteData_i = b;
        ByteDone_i = 1'b1;
        tick();
        ByteDone_i = 1'b0;
    endtask

    task automatic start_txn();
        Active_i = 1'b1;
        tick();
        check("start_err", AddrError_o, 0);
        check("start_tx", TxByte_o, 0);
    endtask

    task automatic end_txn();
        Active_i = 1'b0;
        tick(2);
    endtask

    task automatic write_txn(input int addr, input logic [7:0] data[$]);
        int a;
        start_txn();
        send(8'(addr));
        check("wcmd_strobe", WriteStrobe_o, 0);
        tick(2);
        foreach (data[i]) begin
            a = (addr + i) % RC;
            send(data[i]);
            mregs[a] = data[i];
            check("wr_strobe", WriteStrobe_o, 1);
            check("wr_addr", WriteAddr_o, a);
            check("wr_reg", Regs_o[8*a +: 8], data[i]);
            tick();
            check("wr_strobe_off", WriteStrobe_o, 0);
            tick();
        end
        end_txn();
        check_regs("wr_regs");
    endtask

    task automatic read_txn(input int addr, input int n);
        start_txn();
        send(8'h80 | 8'(addr));
        check("rd_first", TxByte_o, mregs[addr]);
        tick(2);
        for (int i = 0; i < n; i++) begin
            send(8'($urandom));
            check("rd_next", TxByte_o, mregs[(addr + i + 1) % RC]);
            check("rd_strobe", WriteStrobe_o, 0);
            tick(2);
        end
        end_txn();
        check_regs("rd_regs");
    endtask

    task automatic err_txn(input logic [7:0] cmd, input int n);
        start_txn();
        send(cmd);
        check("err_flag", AddrError_o, 1);
        check("err_tx", TxByte_o, 0);
        for (int i = 0; i < n; i++) begin
            tick();
            send(8'($urandom));
            check("err_strobe", WriteStrobe_o, 0);
            check("err_tx2", TxByte_o, 0);
        end
        end_txn();
        check("err_sticky", AddrError_o, 1);
        check_regs("err_regs");
    endtask

    task automatic abort_txn(input int addr);
        start_txn();
        send(8'(addr));
        tick();
        end_txn();
        check("abort_strobe", WriteStrobe_o, 0);
        check_regs("abort_regs");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        int kind, addr, n;

        for (int i = 0; i < RC; i++) mregs[i] = 8'h00;
        Reset = 1'b0;
        Active_i = 1'b0;
        ByteData_i = 8'h00;
        ByteDone_i = 1'b0;
        tick(2);
        check_regs("rst_regs");
        check("rst_tx", TxByte_o, 0);
        check("rst_strobe", WriteStrobe_o, 0);
        check("rst_waddr", WriteAddr_o, 0);
        check("rst_err", AddrError_o, 0);
        Reset = 1'b1;
        tick(2);

        // Reset in the middle of a write, while the strobe is high.
        start_txn();
        send(8'h02);
        tick(2);
        send(8'h5A);
        check("pre_rst_strobe", WriteStrobe_o, 1);
        #2 Reset = 1'b0;
        Active_i = 1'b0;
        #1;
        check_regs("midrst_regs");
        check("midrst_strobe", WriteStrobe_o, 0);
        check("midrst_tx", TxByte_o, 0);
        tick();
        Reset = 1'b1;
        tick(2);

        q = {8'hAA, 8'hBB};
        write_txn(3, q);
        q = {8'h11, 8'h22};
        write_txn(15, q);
        read_txn(15, 2);
        err_txn(8'h20, 1);
        abort_txn(5);
        q = {8'h77};
        write_txn(5, q);

        // Byte coincident with the start edge is dropped.
        Active_i = 1'b1;
        ByteData_i = 8'h85;
        ByteDone_i = 1'b1;
        tick();
        ByteDone_i = 1'b0;
        check("edge_tx", TxByte_o, 0);
        tick();
        send(8'h06);
        check("edge_cmd_strobe", WriteStrobe_o, 0);
        tick(2);
        send(8'h99);
        mregs[6] = 8'h99;
        check("edge_wr_strobe", WriteStrobe_o, 1);
        check("edge_wr_addr", WriteAddr_o, 6);

        // Byte coincident with Active falling is ignored.
        tick(2);
        ByteData_i = 8'hEE;
        ByteDone_i = 1'b1;
        Active_i = 1'b0;
        tick();
        ByteDone_i = 1'b0;
        check("fall_strobe", WriteStrobe_o, 0);
        tick();
        check_regs("fall_regs");

        // Byte while idle is ignored.
        send(8'h44);
        check("idle_strobe", WriteStrobe_o, 0);
        tick();

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            addr = $urandom_range(0, RC - 1);
            n = $urandom_range(1, 5);
            case (kind)
                0: begin
                    q = {};
                    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                    write_txn(addr, q);
                end
                1: read_txn(addr, n);
                2: err_txn({1'($urandom), 7'($urandom_range(RC, 127))}, n);
                default: abort_txn(addr);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_register_bank.md
Name: spi_register_bank

Overview:
- Byte-level command decoder and register file behind the SPI slave receiver.
- Consumes each received byte plus its done strobe and interprets the first byte of a transaction as a command (read/write + start address).
- Subsequent bytes are written to, or read from, consecutive registers with auto-increment.
- Drives the byte presented to the SPI slave for MISO and exposes all registers to fabric logic.

Parameters:
REG_COUNT, 16, number of 8-bit registers; must be a power of two, 2..128
ADDR_WIDTH, 4, log2(REG_COUNT); internal address pointer width
RESET_VALUE, 8'h00, value loaded into every register on reset

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Active_i  input  1  transaction in progress (synchronized chip select, active high = CS low)
ByteData_i  input  8  byte received from the SPI slave; valid when ByteDone_i is high
ByteDone_i  input  1  one-cycle strobe, one per received byte
TxByte_o  output  8  byte for the SPI slave to shift out next
Regs_o  output  8*REG_COUNT  flattened register contents; reg n at [8n+7:8n]
WriteStrobe_o  output  1  one-cycle pulse when a register is written
WriteAddr_o  output  ADDR_WIDTH  address of the write flagged by WriteStrobe_o
AddrError_o  output  1  sticky; set by a command byte with address >= REG_COUNT; cleared at the next transaction start

Behaviour:
- Reset (async, Reset low) values:
  - state = IDLE; pointer = 0.
  - all registers = RESET_VALUE.
  - TxByte_o = 8'h00; WriteStrobe_o = 0; WriteAddr_o = 0; AddrError_o = 0.
- All other logic is synchronous to rising Clock.
- States: IDLE, CMD, WRITE, READ, DISCARD.
- IDLE -> CMD on a rising edge of Active_i (detected internally, one-cycle latency).
  - On that transition: AddrError_o cleared; TxByte_o = 8'h00.
- Any state -> IDLE when Active_i is low. This is an abort: a partial byte is never acted on, and registers keep their last written values.
- CMD, on ByteDone_i, decodes ByteData_i: bit7 = 1 read, 0 write; bits[6:0] = address.
  - Address >= REG_COUNT: AddrError_o = 1 -> DISCARD.
  - Write command: pointer = address -> WRITE.
  - Read command: pointer = address -> READ; TxByte_o = reg[address] on the next cycle (one-cycle latency after ByteDone_i).
- WRITE, on ByteDone_i:
  - reg[pointer] = ByteData_i.
  - WriteStrobe_o = 1 for exactly one cycle, with WriteAddr_o = pointer.
  - pointer = pointer + 1 modulo REG_COUNT (wraps REG_COUNT-1 -> 0).
- READ, on ByteDone_i:
  - pointer increments modulo REG_COUNT.
  - TxByte_o = reg[new pointer] one cycle later.
  - Received bytes are ignored and no register is modified.
- DISCARD: all bytes ignored; TxByte_o = 8'h00; no writes; stays until Active_i low.
- Regs_o is registered and reflects a write one cycle after ByteDone_i, i.e. the same cycle WriteStrobe_o is high.
- A ByteDone_i coincident with Active_i falling is ignored.
- A ByteDone_i seen while in IDLE is ignored.
- Active_i rising in the same cycle as ByteDone_i: the edge takes priority and the byte is dropped.
- Read-after-write within one transaction is impossible (mode is fixed by the command). Across transactions, reads return the latest written data.

Test Plan:
- Reset mid-WRITE transaction -> all Regs_o bytes = RESET_VALUE, state IDLE, WriteStrobe_o = 0, TxByte_o = 00.
- Active_i high, bytes 0x03, 0xAA, 0xBB -> reg3 = AA, reg4 = BB; two WriteStrobe_o pulses with WriteAddr_o = 3 then 4; Active_i low -> IDLE.
- Write 0x0F, 0x11, 0x22 with REG_COUNT = 16 -> reg15 = 11, reg0 = 22 (wrap); WriteAddr_o sequence 15, 0.
- After the above, read 0x8F then two dummy bytes -> TxByte_o = 11 one cycle after the command done, then 22, then reg1 value; no register changes.
- Command 0x20 (address 32 >= 16), then 0x55 -> AddrError_o = 1, no WriteStrobe_o, TxByte_o = 00; next transaction start clears AddrError_o.
- Drop Active_i after the command 0x05 and before any data byte, then a new transaction writing 0x05, 0x77 -> reg5 = 77 only; no spurious write from the aborted transaction.
